// File: rtl/alu.sv
// RV32I integer ALU for the execute stage: combinational result, zero flag
// and a registered copy of the result for the pipeline.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset (clears alu_res_q only)
//   rs1       : operand A (register value or PC via the ASel mux)
//   rs2       : operand B (register value or immediate via the BSel mux)
//   ALUsel    : operation select (see alu_op_e)
//   alu_res   : combinational result
//   alu_res_q : alu_res registered on rising clk
//   zero      : combinational, high when alu_res is zero

package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_JADD  = 4'd10,
        ALU_LUIOP = 4'd11
    } alu_op_e;

endpackage

module alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [3:0]  ALUsel,
    output logic [31:0] alu_res,
    output logic [31:0] alu_res_q,
    output logic        zero
);

    logic [15:0] op_oh;
    logic [4:0]  shamt;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] sll_r;
    logic [31:0] srl_r;
    logic [31:0] sra_r;
    logic        lt_s;
    logic        lt_u;

    // One-hot decode of the select; codes 12..15 match no arm below.
    assign op_oh = 16'b1 << ALUsel;

    assign shamt = rs2[4:0];
    assign sum   = rs1 + rs2;
    assign diff  = rs1 - rs2;
    assign sll_r = rs1 << shamt;
    assign srl_r = rs1 >> shamt;
    assign sra_r = $unsigned($signed(rs1) >>> shamt);
    assign lt_s  = $signed(rs1) < $signed(rs2);
    assign lt_u  = rs1 < rs2;

    always_comb begin
        alu_res = 32'h0000_0000;
        unique case (1'b1)
            op_oh[ALU_ADD]:   alu_res = sum;
            op_oh[ALU_SUB]:   alu_res = diff;
            op_oh[ALU_SLL]:   alu_res = sll_r;
            op_oh[ALU_SLT]:   alu_res = {31'b0, lt_s};
            op_oh[ALU_SLTU]:  alu_res = {31'b0, lt_u};
            op_oh[ALU_XOR]:   alu_res = rs1 ^ rs2;
            op_oh[ALU_SRL]:   alu_res = srl_r;
            op_oh[ALU_SRA]:   alu_res = sra_r;
            op_oh[ALU_OR]:    alu_res = rs1 | rs2;
            op_oh[ALU_AND]:   alu_res = rs1 & rs2;
            // Jump target: bit 0 cleared as JALR requires.
            op_oh[ALU_JADD]:  alu_res = sum & 32'hFFFF_FFFE;
            op_oh[ALU_LUIOP]: alu_res = rs2;
            default:          alu_res = 32'h0000_0000;
        endcase
    end

    assign zero = (alu_res == 32'h0000_0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_res_q <= 32'h0000_0000;
        end else begin
            alu_res_q <= alu_res;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: table of directed vectors, random vectors against a
// reference model, scoreboard for the registered result, reset sequences.

module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  ALUsel;
    logic [31:0] alu_res;
    logic [31:0] alu_res_q;
    logic        zero;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    alu alu1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1       (rs1),
        .rs2       (rs2),
        .ALUsel    (ALUsel),
        .alu_res   (alu_res),
        .alu_res_q (alu_res_q),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ext;
        int          s;
        s = int'(b[4:0]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + ~b + 32'd1;
            4'd2:  return a << s;
            4'd3:  begin
                if (a[31] != b[31]) return {31'b0, a[31]};
                return {31'b0, a < b};
            end
            4'd4:  return {31'b0, a < b};
            4'd5:  return a ^ b;
            4'd6:  return a >> s;
            4'd7:  begin
                ext = {{32{a[31]}}, a};
                ext = ext >> s;
                return ext[31:0];
            end
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return {(a + b) >> 1, 1'b0};
            4'd11: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic add_vec(input string n, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e);
        vec_t v;
        v.name = n;
        v.op   = op;
        v.a    = a;
        v.b    = b;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    // Drive at negedge, check comb outputs, then check the register
    // through the scoreboard after the next rising edge.
    task automatic apply(input vec_t v);
        logic [31:0] e;
        @(negedge clk);
        ALUsel = v.op;
        rs1    = v.a;
        rs2    = v.b;
        #1;
        chk({v.name, " res"}, alu_res, v.exp);
        chk({v.name, " zero"}, {31'b0, zero}, {31'b0, v.exp == 32'd0});
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s q: scoreboard empty", v.name);
        end else begin
            e = exp_q.pop_front();
            chk({v.name, " q"}, alu_res_q, e);
        end
    endtask

    initial begin
        add_vec("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0);
        add_vec("add", 4'd0, 32'd100, 32'd23, 32'd123);
        add_vec("sub_neg", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
        add_vec("sub_eq", 4'd1, 32'h1234, 32'h1234, 32'h0);
        add_vec("slt_min", 4'd3, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1);
        add_vec("sltu_min", 4'd4, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0);
        add_vec("slt_eq", 4'd3, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h0);
        add_vec("sltu_eq", 4'd4, 32'h55, 32'h55, 32'h0);
        add_vec("sltu_lt", 4'd4, 32'h1, 32'hFFFF_FFFF, 32'h1);
        add_vec("slt_pos", 4'd3, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0);
        add_vec("sra4", 4'd7, 32'h8000_0000, 32'h24, 32'hF800_0000);
        add_vec("srl4", 4'd6, 32'h8000_0000, 32'h24, 32'h0800_0000);
        add_vec("sll31", 4'd2, 32'h1, 32'd31, 32'h8000_0000);
        add_vec("sll0", 4'd2, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF);
        add_vec("sra0", 4'd7, 32'h8000_0001, 32'hFFFF_FFE0, 32'h8000_0001);
        add_vec("sra_pos", 4'd7, 32'h4000_0000, 32'd30, 32'h1);
        add_vec("jadd", 4'd10, 32'h1001, 32'h4, 32'h1004);
        add_vec("luiop", 4'd11, 32'hFFFF_FFFF, 32'h1234_5000, 32'h1234_5000);
        add_vec("op12", 4'd12, 32'h1, 32'h2, 32'h0);
        add_vec("op13", 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        add_vec("op15", 4'd15, 32'h7, 32'h9, 32'h0);
        add_vec("and", 4'd9, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        add_vec("or", 4'd8, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
        add_vec("xor", 4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);

        // Reset asserted with no clock edge: register clears at once.
        rst_n  = 1'b1;
        ALUsel = 4'd0;
        rs1    = 32'd2;
        rs2    = 32'd3;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_q", alu_res_q, 32'h0);
        chk("rst_res", alu_res, 32'd5);
        @(posedge clk);
        #1;
        chk("rst_q_hold", alu_res_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_res", alu_res, 32'd5);
        chk("post_rst_q", alu_res_q, 32'h0);
        @(posedge clk);
        #1;
        chk("first_load_q", alu_res_q, 32'd5);

        foreach (vecs[i]) apply(vecs[i]);

        for (int i = 0; i < 24; i++) begin
            vec_t v;
            v.name = "rand";
            v.op   = 4'($urandom_range(0, 15));
            v.a    = $urandom;
            v.b    = (i % 4 == 0) ? v.a : $urandom;
            v.exp  = model(v.op, v.a, v.b);
            apply(v);
        end

        // Reset mid-cycle while the register holds a nonzero value.
        @(negedge clk);
        ALUsel = 4'd0;
        rs1    = 32'd7;
        rs2    = 32'd9;
        @(posedge clk);
        #1;
        chk("mid_q_before", alu_res_q, 32'd16);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_q", alu_res_q, 32'h0);
        chk("mid_rst_res", alu_res, 32'd16);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_reload_q", alu_res_q, 32'd16);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
